dmem_responder: RTL and testbench

Request/response data-memory responder for the Y86-64 processor: the target side of the data-memory access interface driven by the memory stage. It accepts one read or write request per transaction through a valid/ready handshake and performs it on a 64-bit-word array after a programmable latency. It returns read data, or the written word, plus an out-of-range error flag on a held response channel. It replaces the memory array embedded in the memory stage, so stage logic and storage can be verified separately.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
package dmem_pkg;

    localparam int WORD_W     = 64;
    localparam int DMEM_DEPTH = 1024;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_t;

    // Y86-64 icodes that touch data memory; the memory stage uses these to derive req_write.
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // True for the icodes that store to memory.
    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array with write enable and a registered read port.
// A write returns the written word on the read port (write-first).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage write.
    // NOTE: the array has no reset on purpose; resetting every word would turn it into flops.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port; holds its value between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write per transaction, performs it after
// LATENCY access cycles and holds the response until the requester takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t       state, state_nxt;
    logic              write_q;
    logic [63:0]       addr_q;
    logic [63:0]       wdata_q;
    logic [3:0]        wait_cnt;
    logic              err_q;
    logic [WORD_W-1:0] arr_rdata;

    logic accept;
    logic access_go;
    logic in_range;

    assign accept    = req_valid && (state == ST_IDLE);
    assign access_go = (state == ST_ACCESS) && (wait_cnt == 4'd0);
    // Full-width unsigned compare so huge addresses never alias into the array.
    assign in_range  = addr_q < 64'(DEPTH);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)                 state_nxt = ST_ACCESS;
            ST_ACCESS: if (wait_cnt == 4'd0)       state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)              state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; response data is gated to zero outside RESP and on error.
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rsp_error = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q) ? arr_rdata : '0;
    end

    // Request capture, access countdown and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wait_cnt <= 4'(LATENCY - 1);
            end else if ((state == ST_ACCESS) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access_go) begin
                err_q <= !in_range;
            end
        end
    end

    // Storage; only touched on the final access cycle of an in-range request.
    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access_go && in_range),
        .we    (write_q),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=1 and LATENCY=4) checked against
// an associative-array memory model.
module tb_dmem_responder;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_error [2];

    int checks   = 0;
    int failures = 0;

    // Reference memory: key = {dut index, word address}.
    logic [63:0] model_mem [bit [64:0]];

    always #(PERIOD/2) clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_error (rsp_error[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut_l4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_error (rsp_error[1])
    );

    function automatic int exp_lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Expected response from the memory rules; updates the model on in-range writes.
    function automatic void model_step(input int d, input logic wr, input logic [63:0] a,
                                       input logic [63:0] w, output logic [63:0] ed,
                                       output logic ee);
        bit [64:0] key;
        key = {d[0], a};
        if (a >= 64'd1024) begin
            ed = 64'd0;
            ee = 1'b1;
        end else if (wr) begin
            model_mem[key] = w;
            ed = w;
            ee = 1'b0;
        end else begin
            ed = model_mem.exists(key) ? model_mem[key] : 64'hDEAD_DEAD_DEAD_DEAD;
            ee = 1'b0;
        end
    endfunction

    // Present a request (caller is at a negedge, DUT idle), then wait for rsp_valid.
    // lat counts rising edges after acceptance until rsp_valid is seen.
    task automatic issue(input int d, input logic wr, input logic [63:0] a, input logic [63:0] w,
                         input logic [63:0] a_after, input logic [63:0] w_after,
                         output int lat, output time t_acc);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready dut%0d: req_ready=%b required 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = w;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = a_after;
        req_wdata[d] = w_after;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Check the held response, perform the handshake and confirm the return to idle.
    task automatic complete(input int d, input logic [63:0] ed, input logic ee);
        checks++;
        if (rsp_rdata[d] !== ed) begin
            failures++;
            $display("FAIL rsp_rdata dut%0d: got %h required %h", d, rsp_rdata[d], ed);
        end
        checks++;
        if (rsp_error[d] !== ee) begin
            failures++;
            $display("FAIL rsp_error dut%0d: got %b required %b", d, rsp_error[d], ee);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL after_handshake dut%0d: rsp_valid=%b req_ready=%b required 0/1",
                     d, rsp_valid[d], req_ready[d]);
        end
    endtask

    // Full transaction with model-derived expectations and a latency check.
    task automatic txn(input int d, input logic wr, input logic [63:0] a, input logic [63:0] w,
                       output time t_acc);
        logic [63:0] ed;
        logic        ee;
        int          lat;
        model_step(d, wr, a, w, ed, ee);
        issue(d, wr, a, w, {$urandom, $urandom}, {$urandom, $urandom}, lat, t_acc);
        checks++;
        if (lat != exp_lat(d)) begin
            failures++;
            $display("FAIL latency dut%0d addr=%h: got %0d edges required %0d", d, a, lat, exp_lat(d));
        end
        complete(d, ed, ee);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
                rsp_rdata[d] !== 64'd0 || rsp_error[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s dut%0d: ready=%b valid=%b rdata=%h error=%b required 1/0/0/0",
                         tag, d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_error[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 64'd0;
            req_wdata[d] = 64'd0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_in");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_out");
    endtask

    task automatic test_write_read();
        time t;
        txn(0, 1'b1, 64'd5, 64'h1122_3344_5566_7788, t);
        txn(0, 1'b0, 64'd5, 64'd0, t);
    endtask

    task automatic test_boundary();
        time t;
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 64'd0,    64'h0000_0000_0000_AAAA, t);
            txn(d, 1'b1, 64'd1023, 64'hCAFE_F00D_0123_4567, t);
            txn(d, 1'b0, 64'd1023, 64'd0, t);
            txn(d, 1'b0, 64'd1024, 64'd0, t);
            txn(d, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, t);
            txn(d, 1'b1, 64'd1024, 64'h5555_5555_5555_5555, t);
            txn(d, 1'b0, 64'd1023, 64'd0, t);
            txn(d, 1'b0, 64'd0,    64'd0, t);
        end
    endtask

    task automatic test_backpressure();
        time         t;
        int          lat;
        logic [63:0] ed;
        logic        ee;
        txn(0, 1'b1, 64'd3, 64'hA5, t);
        issue(0, 1'b0, 64'd3, 64'd0, 64'd77, 64'd0, lat, t);
        // A competing write is presented while the response is held.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 64'd3;
        req_wdata[0] = 64'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 64'hA5 ||
                rsp_error[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold cycle %0d: valid=%b rdata=%h error=%b ready=%b required 1/a5/0/0",
                         i, rsp_valid[0], rsp_rdata[0], rsp_error[0], req_ready[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: ready=%b valid=%b required 1/0", req_ready[0], rsp_valid[0]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_accept: req_ready=%b required 0", req_ready[0]);
        end
        lat = 0;
        while (rsp_valid[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        model_step(0, 1'b1, 64'd3, 64'h5A, ed, ee);
        complete(0, ed, ee);
        txn(0, 1'b0, 64'd3, 64'd0, t);
    endtask

    task automatic test_latency();
        time t;
        txn(1, 1'b1, 64'd42, 64'h0BAD_BEEF_0000_0042, t);
        txn(1, 1'b0, 64'd42, 64'd0, t);
    endtask

    task automatic test_back_to_back();
        time t1, t2;
        for (int d = 0; d < 2; d++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            txn(d, 1'b1, 64'd20, v, t1);
            txn(d, 1'b0, 64'd20, 64'd0, t2);
            checks++;
            if ((t2 - t1) != time'((exp_lat(d) + 2) * PERIOD)) begin
                failures++;
                $display("FAIL b2b_spacing dut%0d: got %0t required %0d", d, t2 - t1, (exp_lat(d) + 2) * PERIOD);
            end
        end
    endtask

    task automatic test_reset_mid();
        time t;
        txn(1, 1'b1, 64'd7, 64'h1, t);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 64'd7;
        req_wdata[1] = 64'hDEAD_0000_0000_0007;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 64'd7, 64'd0, t);
    endtask

    task automatic test_input_stability();
        time         t;
        int          lat;
        logic [63:0] ed;
        logic        ee;
        txn(1, 1'b1, 64'd10, 64'h1010_1010, t);
        model_step(1, 1'b1, 64'd9, 64'hBEEF, ed, ee);
        issue(1, 1'b1, 64'd9, 64'hBEEF, 64'd10, 64'hFFFF_0000_FFFF_0000, lat, t);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL stability_latency: got %0d required 4", lat);
        end
        complete(1, ed, ee);
        txn(1, 1'b0, 64'd9, 64'd0, t);
        txn(1, 1'b0, 64'd10, 64'd0, t);
    endtask

    task automatic test_random();
        time         t;
        int          d;
        int          r;
        logic        wr;
        logic [63:0] a;
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            if (r == 0) a = 64'd1024 + 64'($urandom_range(0, 100000));
            else if (r == 1) a = 64'd1008 + 64'($urandom_range(0, 15));
            else a = 64'($urandom_range(0, 15));
            wr = 1'($urandom);
            if (!wr && a < 64'd1024 && !model_mem.exists({d[0], a})) wr = 1'b1;
            txn(d, wr, a, {$urandom, $urandom}, t);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_backpressure();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_input_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(200000 * PERIOD);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
